// File: rtl/riscv_id_pkg.sv
// Shared decode types for the ID stage: immediate-select codes, opcodes, decoded control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_id_pkg;

  typedef enum logic [2:0] {
    IMM_U    = 3'b000,
    IMM_J    = 3'b001,
    IMM_S    = 3'b010,
    IMM_B    = 3'b011,
    IMM_I    = 3'b100,
    IMM_ISH  = 3'b101,
    IMM_IU   = 3'b110,
    IMM_NONE = 3'b111
  } imm_sel_e;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_FENCE  = 7'h0F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  // Decoded control flags; uses_rs1/uses_rs2 only feed the load-use hazard check.
  typedef struct packed {
    imm_sel_e imm_sel;
    logic     is_load;
    logic     is_store;
    logic     is_branch;
    logic     is_jump;
    logic     reg_write;
    logic     illegal;
    logic     uses_rs1;
    logic     uses_rs2;
  } id_ctrl_t;

  localparam id_ctrl_t ID_CTRL_RESET = '{
    imm_sel:   IMM_NONE,
    is_load:   1'b0,
    is_store:  1'b0,
    is_branch: 1'b0,
    is_jump:   1'b0,
    reg_write: 1'b0,
    illegal:   1'b0,
    uses_rs1:  1'b0,
    uses_rs2:  1'b0
  };

endpackage

// File: rtl/id_opcode_decoder.sv
// Opcode/funct3 decoder: raw instruction word -> immediate select and control flags.
// Latency: purely combinational.
// Backpressure: none; caller decides when the result is registered.
module id_opcode_decoder
  import riscv_id_pkg::*;
(
  input  logic [31:0] instr_i,
  output id_ctrl_t    ctrl_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       rd_nz;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign rd_nz  = |instr_i[11:7];

  // Table decode; anything not listed is flagged illegal with no immediate.
  always_comb begin
    ctrl_o = ID_CTRL_RESET;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        ctrl_o.imm_sel   = IMM_U;
        ctrl_o.reg_write = rd_nz;
      end
      OPC_JAL: begin
        ctrl_o.imm_sel   = IMM_J;
        ctrl_o.is_jump   = 1'b1;
        ctrl_o.reg_write = rd_nz;
      end
      OPC_JALR: begin
        ctrl_o.imm_sel   = IMM_I;
        ctrl_o.is_jump   = 1'b1;
        ctrl_o.reg_write = rd_nz;
        ctrl_o.uses_rs1  = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_o.imm_sel   = IMM_B;
        ctrl_o.is_branch = 1'b1;
        ctrl_o.uses_rs1  = 1'b1;
        ctrl_o.uses_rs2  = 1'b1;
      end
      OPC_LOAD: begin
        ctrl_o.imm_sel   = IMM_I;
        ctrl_o.is_load   = 1'b1;
        ctrl_o.reg_write = rd_nz;
        ctrl_o.uses_rs1  = 1'b1;
      end
      OPC_STORE: begin
        ctrl_o.imm_sel   = IMM_S;
        ctrl_o.is_store  = 1'b1;
        ctrl_o.uses_rs1  = 1'b1;
        ctrl_o.uses_rs2  = 1'b1;
      end
      OPC_OPIMM: begin
        ctrl_o.imm_sel   = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_ISH : IMM_I;
        ctrl_o.reg_write = rd_nz;
        ctrl_o.uses_rs1  = 1'b1;
      end
      OPC_OP: begin
        ctrl_o.imm_sel   = IMM_NONE;
        ctrl_o.reg_write = rd_nz;
        ctrl_o.uses_rs1  = 1'b1;
        ctrl_o.uses_rs2  = 1'b1;
      end
      OPC_FENCE: begin
        ctrl_o.imm_sel   = IMM_NONE;
      end
      OPC_SYSTEM: begin
        ctrl_o.imm_sel   = IMM_IU;
        ctrl_o.reg_write = rd_nz;
        // CSR register forms (funct3 001..011) read rs1; immediate forms carry zimm there.
        ctrl_o.uses_rs1  = (funct3 != 3'b000) && !funct3[2];
      end
      default: begin
        ctrl_o.imm_sel   = IMM_NONE;
        ctrl_o.illegal   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_decode_ctrl.sv
// ID-stage control: decodes IF instructions into a one-entry ID/EX slot, inserts load-use bubbles, honours flush.
// Latency: 1 cycle from accepted input to out_valid.
// Backpressure: in_ready drops while the slot is held by EX or a load-use hazard exists (ID_LOAD_USE_STALL_EN); flush forces in_ready.
module id_decode_ctrl
  import riscv_id_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [24:0]     out_payload,
  output logic [2:0]      out_imm_sel,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic            out_is_load,
  output logic            out_is_store,
  output logic            out_is_branch,
  output logic            out_is_jump,
  output logic            out_reg_write,
  output logic            out_illegal
);

  id_ctrl_t        dec;
  id_ctrl_t        ctrl_d, ctrl_q;
  logic            valid_d, valid_q;
  logic [24:0]     payload_d, payload_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic            hazard;
  logic            load;
  logic [4:0]      in_rs1, in_rs2;
  logic            unused_ok;

  id_opcode_decoder u_dec (
    .instr_i (in_instr),
    .ctrl_o  (dec)
  );

  assign in_rs1 = in_instr[19:15];
  assign in_rs2 = in_instr[24:20];

  // Register indices live inside the stored payload (payload bit k = instr bit k+7).
  assign out_rd  = payload_q[4:0];
  assign out_rs1 = payload_q[12:8];
  assign out_rs2 = payload_q[17:13];

`ifdef ID_LOAD_USE_STALL_EN
  // Stall while a load in the slot writes a register the incoming instruction actually reads.
  assign hazard = in_valid && valid_q && ctrl_q.is_load && (out_rd != 5'd0) &&
                  ((dec.uses_rs1 && (in_rs1 == out_rd)) ||
                   (dec.uses_rs2 && (in_rs2 == out_rd)));
`else
  // Forwarding downstream resolves load-use; never stall here.
  assign hazard = 1'b0;
`endif

  // Operand-use flags only matter to the hazard check; sink them so every build is lint-clean.
  assign unused_ok = ^{dec.uses_rs1, dec.uses_rs2, ctrl_q.uses_rs1, ctrl_q.uses_rs2, in_rs1, in_rs2};

  assign in_ready = flush || ((!valid_q || out_ready) && !hazard);
  assign load     = in_valid && in_ready && !flush;

  // Slot next state: flush kills, accept loads, consume empties, otherwise hold.
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    pc_d      = pc_q;
    ctrl_d    = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d   = 1'b1;
      payload_d = in_instr[31:7];
      pc_d      = in_pc;
      ctrl_d    = dec;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // ID/EX slot register; reset clears the slot and parks imm_sel on the zero-immediate code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      pc_q      <= '0;
      ctrl_q    <= ID_CTRL_RESET;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      pc_q      <= pc_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_payload   = payload_q;
  assign out_pc        = pc_q;
  assign out_imm_sel   = ctrl_q.imm_sel;
  assign out_is_load   = ctrl_q.is_load;
  assign out_is_store  = ctrl_q.is_store;
  assign out_is_branch = ctrl_q.is_branch;
  assign out_is_jump   = ctrl_q.is_jump;
  assign out_reg_write = ctrl_q.reg_write;
  assign out_illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_id_decode_ctrl.sv
// Directed bench for id_decode_ctrl: scoreboard of decoded slot contents against a reference decode model.
// Latency: checks in_ready each cycle before the edge and every slot output after it.
// Backpressure: drives out_ready/flush directly and holds in_valid until the model accepts.
module tb_id_decode_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_payload;
  logic [2:0]  out_imm_sel;
  logic [31:0] out_pc;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        out_is_load, out_is_store, out_is_branch, out_is_jump, out_reg_write, out_illegal;

  id_decode_ctrl #(.XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_payload   (out_payload),
    .out_imm_sel   (out_imm_sel),
    .out_pc        (out_pc),
    .out_rd        (out_rd),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_is_load   (out_is_load),
    .out_is_store  (out_is_store),
    .out_is_branch (out_is_branch),
    .out_is_jump   (out_is_jump),
    .out_reg_write (out_reg_write),
    .out_illegal   (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] payload;
    logic [2:0]  imm;
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic        ld, st, br, jp, rw, ill, u1, u2;
  } exp_t;

  exp_t sbq[$];
  exp_t m_slot;
  logic m_valid;
  logic last_acc;
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [31:0] I_LUI    = 32'h123450B7; // lui  x1,0x12345
  localparam logic [31:0] I_JAL    = 32'h008000EF; // jal  x1,8
  localparam logic [31:0] I_SW     = 32'h00512223; // sw   x5,4(x2)
  localparam logic [31:0] I_BEQ    = 32'h00208463; // beq  x1,x2,8
  localparam logic [31:0] I_ADDI   = 32'h00508193; // addi x3,x1,5
  localparam logic [31:0] I_SLLI   = 32'h00219213; // slli x4,x3,2
  localparam logic [31:0] I_CSRRW  = 32'h300312F3; // csrrw x5,0x300,x6
  localparam logic [31:0] I_LW5    = 32'h00012283; // lw   x5,0(x2)
  localparam logic [31:0] I_LW7    = 32'h00012383; // lw   x7,0(x2)
  localparam logic [31:0] I_LW0    = 32'h00012003; // lw   x0,0(x2)
  localparam logic [31:0] I_ADD    = 32'h00728333; // add  x6,x5,x7
  localparam logic [31:0] I_ADD0   = 32'h00100333; // add  x6,x0,x1
  localparam logic [31:0] I_LUI5   = 32'h000012B7; // lui  x5,1
  localparam logic [31:0] I_FENCE  = 32'h0000000F;
  localparam logic [31:0] I_BAD    = 32'h0000007F;

  function automatic exp_t reset_exp();
    exp_t e;
    e.payload = '0; e.imm = 3'b111; e.pc = '0;
    e.rd = '0; e.rs1 = '0; e.rs2 = '0;
    e.ld = 0; e.st = 0; e.br = 0; e.jp = 0; e.rw = 0; e.ill = 0; e.u1 = 0; e.u2 = 0;
    return e;
  endfunction

  // Reference decode straight from the instruction-set encoding table.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    logic [2:0] f3;
    logic       nz;
    e = reset_exp();
    f3 = i[14:12];
    nz = (i[11:7] != 5'd0);
    e.payload = i[31:7]; e.pc = pc;
    e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
    case (i[6:0])
      7'h37, 7'h17: begin e.imm = 3'b000; e.rw = nz; end
      7'h6F: begin e.imm = 3'b001; e.jp = 1; e.rw = nz; end
      7'h67: begin e.imm = 3'b100; e.jp = 1; e.rw = nz; e.u1 = 1; end
      7'h63: begin e.imm = 3'b011; e.br = 1; e.u1 = 1; e.u2 = 1; end
      7'h03: begin e.imm = 3'b100; e.ld = 1; e.rw = nz; e.u1 = 1; end
      7'h23: begin e.imm = 3'b010; e.st = 1; e.u1 = 1; e.u2 = 1; end
      7'h13: begin e.imm = (f3 == 3'b001 || f3 == 3'b101) ? 3'b101 : 3'b100; e.rw = nz; e.u1 = 1; end
      7'h33: begin e.imm = 3'b111; e.rw = nz; e.u1 = 1; e.u2 = 1; end
      7'h0F: begin e.imm = 3'b111; end
      7'h73: begin e.imm = 3'b110; e.rw = nz; e.u1 = (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011); end
      default: begin e.imm = 3'b111; e.ill = 1; end
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_out();
    chk("out_valid",     {63'd0, out_valid},     {63'd0, m_valid});
    chk("out_payload",   {39'd0, out_payload},   {39'd0, m_slot.payload});
    chk("out_imm_sel",   {61'd0, out_imm_sel},   {61'd0, m_slot.imm});
    chk("out_pc",        {32'd0, out_pc},        {32'd0, m_slot.pc});
    chk("out_rd",        {59'd0, out_rd},        {59'd0, m_slot.rd});
    chk("out_rs1",       {59'd0, out_rs1},       {59'd0, m_slot.rs1});
    chk("out_rs2",       {59'd0, out_rs2},       {59'd0, m_slot.rs2});
    chk("out_is_load",   {63'd0, out_is_load},   {63'd0, m_slot.ld});
    chk("out_is_store",  {63'd0, out_is_store},  {63'd0, m_slot.st});
    chk("out_is_branch", {63'd0, out_is_branch}, {63'd0, m_slot.br});
    chk("out_is_jump",   {63'd0, out_is_jump},   {63'd0, m_slot.jp});
    chk("out_reg_write", {63'd0, out_reg_write}, {63'd0, m_slot.rw});
    chk("out_illegal",   {63'd0, out_illegal},   {63'd0, m_slot.ill});
  endtask

  // One cycle with inputs already applied after a falling edge.
  task automatic cyc();
    exp_t d;
    logic hz, rdy, acc;
    #1;
    d  = model(in_instr, in_pc);
    hz = 1'b0;
`ifdef ID_LOAD_USE_STALL_EN
    hz = in_valid && m_valid && m_slot.ld && (m_slot.rd != 5'd0) &&
         ((d.u1 && d.rs1 == m_slot.rd) || (d.u2 && d.rs2 == m_slot.rd));
`endif
    rdy = flush || ((!m_valid || out_ready) && !hz);
    chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
    acc = in_valid && rdy && !flush;
    if (acc) sbq.push_back(d);
    last_acc = acc;
    @(posedge clk);
    #1;
    if (flush) m_valid = 1'b0;
    else if (acc) begin
      m_slot  = sbq.pop_front();
      m_valid = 1'b1;
    end else if (out_ready) m_valid = 1'b0;
    check_out();
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 8 && !done; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = ins; in_pc = pc; flush = 1'b0;
      cyc();
      done = last_acc;
    end
    chk("accepted_in_budget", {63'd0, done}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout reached at %0t", $time);
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    m_valid = 1'b0; m_slot = reset_exp(); last_acc = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check_out();
    rst_n = 1'b1;
    idle(1);

    // Stream one instruction per immediate format
    send(I_LUI,   32'h100);
    send(I_JAL,   32'h104);
    send(I_SW,    32'h108);
    send(I_BEQ,   32'h10C);
    send(I_ADDI,  32'h110);
    send(I_SLLI,  32'h114);
    send(I_CSRRW, 32'h118);
    send(I_FENCE, 32'h11C);
    idle(1);

    // Load-use through rs1, then through rs2, then a non-reading consumer
    send(I_LW5, 32'h200);
    send(I_ADD, 32'h204);
    send(I_LW7, 32'h208);
    send(I_ADD, 32'h20C);
    send(I_LW5, 32'h210);
    send(I_LUI5, 32'h214);
    idle(1);

    // Load to x0 never stalls
    send(I_LW0,  32'h300);
    send(I_ADD0, 32'h304);
    idle(1);

    // EX backpressure: slot full, next instruction waits, then accepted when out_ready returns
    out_ready = 1'b0;
    send(I_ADDI, 32'h400);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = I_SLLI; in_pc = 32'h404; flush = 1'b0;
      cyc();
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = I_SLLI; in_pc = 32'h404;
    cyc();
    chk("accept_after_release", {63'd0, last_acc}, 64'd1);
    idle(1);

    // Flush with slot full and an incoming instruction: both vanish
    out_ready = 1'b0;
    send(I_ADDI, 32'h500);
    @(negedge clk);
    in_valid = 1'b1; in_instr = I_LUI; in_pc = 32'h504; flush = 1'b1;
    cyc();
    idle(2);
    out_ready = 1'b1;
    idle(1);

    // Unrecognised opcode
    send(I_BAD, 32'h600);
    idle(1);

    // Asynchronous reset mid-transfer
    out_ready = 1'b0;
    send(I_JAL, 32'h700);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_valid = 1'b0; m_slot = reset_exp(); sbq.delete();
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(1);
    send(I_ADDI, 32'h800);
    idle(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
